// File: rtl/audio_frame_drain.sv
// ---------------------------------------------------------------------------
// audio_frame_drain
//
// Drains one processed audio frame out of the processor's output buffer and
// serializes it as a stream of 16-bit samples under a valid/ready handshake.
// A frame is BEATS beats of LANES samples each; samples leave in ascending
// global order (LANES*beat + lane).
//
// State | Meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for frame_done; nothing is streamed
// FETCH | output_index has just been driven; waiting out the read latency
// LOAD  | data_out is valid for the current beat; capture it
// STREAM| presenting lanes of the captured beat, one per accepted transfer
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset
//   frame_done    one-cycle pulse: the processor buffer holds a full frame
//   output_index  beat address to the processor read port
//   data_out      processor read data (one cycle after output_index changes)
//   sample_out    serialized sample, two's complement
//   sample_valid  sample_out holds a valid sample
//   sample_ready  downstream accepts the sample
//   busy          high from frame acceptance until the frame is drained
//   frame_drained one-cycle pulse after the final sample transfers
//   overflow      sticky: frame_done seen while a frame was in progress
// ---------------------------------------------------------------------------
module audio_frame_drain #(
    parameter int BEATS = 64,
    parameter int LANES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_done,
    output logic [$clog2(BEATS)-1:0] output_index,
    input  logic [LANES*16-1:0]      data_out,
    output logic [15:0]              sample_out,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     busy,
    output logic                     frame_drained,
    output logic                     overflow
);

    localparam int IW = $clog2(BEATS);
    localparam int LW = $clog2(LANES);
    localparam int DW = LANES * 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LOAD   = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_beat;
    logic [IW-1:0]   r_index;
    logic [LW-1:0]   r_lane;
    logic [DW-1:0]   r_hold;
    logic [15:0]     r_sample;
    logic            r_valid;
    logic            r_busy;
    logic            r_drained;
    logic            r_overflow;

    logic [LW-1:0]   w_next_lane;
    logic [15:0]     w_next_sample;
    logic            w_last_lane;
    logic            w_last_beat;

    // The sample register is loaded one lane ahead on each transfer, so the
    // output stays a pure flop and is naturally stable during stalls.
    assign w_next_lane   = r_lane + 1'b1;
    assign w_next_sample = r_hold[{w_next_lane, 4'b0000} +: 16];
    assign w_last_lane   = (r_lane == LW'(LANES - 1));
    assign w_last_beat   = (r_beat == IW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_index    <= '0;
            r_lane     <= '0;
            r_hold     <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_drained  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_drained <= 1'b0;

            // r_busy is still high in the cycle of the final transfer, so a
            // coincident frame_done lands here and is never accepted below.
            if (frame_done && r_busy) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (frame_done) begin
                        r_state <= FETCH;
                        r_beat  <= '0;
                        r_index <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                FETCH: begin
                    r_state <= LOAD;
                end

                LOAD: begin
                    r_hold   <= data_out;
                    r_lane   <= '0;
                    r_sample <= data_out[15:0];
                    r_valid  <= 1'b1;
                    r_state  <= STREAM;
                end

                STREAM: begin
                    if (sample_ready) begin
                        if (w_last_lane) begin
                            r_valid <= 1'b0;
                            if (w_last_beat) begin
                                r_state   <= IDLE;
                                r_beat    <= '0;
                                r_index   <= '0;
                                r_busy    <= 1'b0;
                                r_drained <= 1'b1;
                            end else begin
                                r_beat  <= r_beat + 1'b1;
                                r_index <= r_index + 1'b1;
                                r_state <= FETCH;
                            end
                        end else begin
                            r_lane   <= w_next_lane;
                            r_sample <= w_next_sample;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign output_index  = r_index;
    assign sample_out    = r_sample;
    assign sample_valid  = r_valid;
    assign busy          = r_busy;
    assign frame_drained = r_drained;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_audio_frame_drain.sv
// ---------------------------------------------------------------------------
// tb_audio_frame_drain
//
// Bench for audio_frame_drain. The processor buffer is modelled as a
// registered read port whose word k holds (base + k). Each accepted frame
// pushes the 2048 expected sample values into a queue; a negedge monitor pops
// one per observed transfer and also checks stall stability, read-address
// stepping and the drained pulse.
// ---------------------------------------------------------------------------
module tb_audio_frame_drain;

    localparam int BEATS = 64;
    localparam int LANES = 32;
    localparam int NS    = BEATS * LANES;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_done;
    logic [5:0]     output_index;
    logic [511:0]   data_out;
    logic [15:0]    sample_out;
    logic           sample_valid;
    logic           sample_ready;
    logic           busy;
    logic           frame_drained;
    logic           overflow;

    audio_frame_drain #(.BEATS(BEATS), .LANES(LANES)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_done   (frame_done),
        .output_index (output_index),
        .data_out     (data_out),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .frame_drained(frame_drained),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Processor buffer: registered read, word k = base + k.
    logic [15:0] mem_base = 16'h0;
    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            data_out[16*l +: 16] <= mem_base + 16'(LANES * int'(output_index) + l);
    end

    // Downstream ready source.
    bit   rdy_rand = 1'b0;
    logic rdy_fix  = 1'b0;
    initial begin
        sample_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sample_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Reference model state.
    logic [15:0] exp_q[$];
    bit          model_busy = 1'b0;
    bit          model_ovf  = 1'b0;
    int          start_cyc;
    int          first_valid_cyc = -1;
    int          last_xfer_cyc = -1;
    int          drained_cyc = -1;
    int          xfer_cnt = 0;
    int          drained_cnt = 0;

    // Monitor.
    bit          stall_prev = 1'b0;
    logic [15:0] prev_out = '0;
    logic [5:0]  prev_idx = '0;
    always @(negedge clk) begin
        logic [15:0] ev;
        if (!rst) begin
            if (sample_valid && !model_busy)
                chk("valid_idle", sample_valid, 1'b0);
            if (sample_valid && first_valid_cyc < 0)
                first_valid_cyc = cyc;
            if (stall_prev) begin
                chk("stall_valid", sample_valid, 1'b1);
                chk("stall_data", sample_out, prev_out);
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    chk("xfer_extra", 1, 0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("sample", sample_out, ev);
                end
                chk("busy_xfer", busy, 1'b1);
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            if (frame_drained) begin
                drained_cnt++;
                drained_cyc = cyc;
                model_busy  = 1'b0;
                chk("drain_busy", busy, 1'b0);
                chk("drain_idx", output_index, 0);
                chk("drain_left", exp_q.size(), 0);
            end
            if (output_index != prev_idx)
                chk("idx_step", (output_index == prev_idx + 6'd1) || (output_index == 6'd0), 1);
            if (output_index > 6'(BEATS - 1))
                chk("idx_range", output_index, BEATS - 1);
        end
        stall_prev = sample_valid && !sample_ready && !rst;
        prev_out   = sample_out;
        prev_idx   = output_index;
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Caller is positioned at posedge+#1 of the cycle that carries frame_done.
    task automatic pulse_frame(input logic [15:0] base);
        if (!model_busy) begin
            mem_base = base;
            exp_q.delete();
            for (int k = 0; k < NS; k++) exp_q.push_back(base + 16'(k));
            model_busy      = 1'b1;
            start_cyc       = cyc;
            first_valid_cyc = -1;
            xfer_cnt        = 0;
        end else begin
            model_ovf = 1'b1;
        end
        frame_done = 1'b1;
        next_cyc();
        frame_done = 1'b0;
    endtask

    // Returns at posedge+#1 of the cycle after the drained pulse.
    task automatic wait_drained(input int limit);
        int n0 = drained_cnt;
        int i  = 0;
        while (drained_cnt == n0 && i < limit) begin
            next_cyc();
            i++;
        end
        if (drained_cnt == n0) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        exp_q.delete();
        model_busy = 1'b0;
        model_ovf  = 1'b0;
    endtask

    initial begin
        int d0;
        int guard;
        rst        = 1'b1;
        frame_done = 1'b0;
        repeat (3) next_cyc();
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", output_index, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_drained", frame_drained, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        next_cyc();

        // Ramp frame, ready held high: exact latency and drain timing.
        rdy_fix = 1'b1;
        next_cyc();
        d0 = drained_cnt;
        pulse_frame(16'h0000);
        chk("busy_start", busy, 1);
        wait_drained(5000);
        chk("ramp_first", first_valid_cyc, start_cyc + 3);
        chk("ramp_last", last_xfer_cyc, start_cyc + 2176);
        chk("ramp_drain", drained_cyc, start_cyc + 2177);
        chk("ramp_count", xfer_cnt, NS);
        chk("ramp_pulses", drained_cnt - d0, 1);
        chk("ramp_ovf", overflow, 0);

        // Random backpressure with a random data base.
        rdy_rand = 1'b1;
        repeat (3) next_cyc();
        d0 = drained_cnt;
        pulse_frame(16'($urandom));
        wait_drained(20000);
        chk("rand_count", xfer_cnt, NS);
        chk("rand_pulses", drained_cnt - d0, 1);
        rdy_rand = 1'b0;

        // Second frame_done 100 cycles into a frame.
        repeat (3) next_cyc();
        d0 = drained_cnt;
        pulse_frame(16'h1000);
        repeat (99) next_cyc();
        pulse_frame(16'h7777);
        chk("ovf_set", overflow, model_ovf);
        wait_drained(5000);
        repeat (20) next_cyc();
        chk("ovf_count", xfer_cnt, NS);
        chk("ovf_pulses", drained_cnt - d0, 1);
        chk("ovf_hold", overflow, 1);
        chk("ovf_idle", busy, 0);
        do_reset();
        chk("ovf_clear", overflow, 0);

        // Reset after 500 transfers, then replay.
        next_cyc();
        pulse_frame(16'h0000);
        guard = 0;
        while (xfer_cnt < 500 && guard < 2000) begin
            next_cyc();
            guard++;
        end
        chk("mid_reach", xfer_cnt, 500);
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        exp_q.delete();
        model_busy = 1'b0;
        chk("mid_valid", sample_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_idx", output_index, 0);
        repeat (5) next_cyc();
        chk("mid_silent", xfer_cnt, 500);
        d0 = drained_cnt;
        pulse_frame(16'h0000);
        wait_drained(5000);
        chk("replay_count", xfer_cnt, NS);
        chk("replay_pulses", drained_cnt - d0, 1);

        // Back-to-back: frame_done in the cycle right after frame_drained.
        pulse_frame(16'($urandom));
        wait_drained(5000);
        chk("b2b_first", first_valid_cyc, start_cyc + 3);
        chk("b2b_drain", drained_cyc, start_cyc + 2177);
        chk("b2b_count", xfer_cnt, NS);
        chk("b2b_ovf", overflow, 0);

        // frame_done coincident with the final transfer.
        repeat (2) next_cyc();
        d0 = drained_cnt;
        pulse_frame(16'($urandom));
        guard = 0;
        while (cyc < start_cyc + 2176 && guard < 5000) begin
            next_cyc();
            guard++;
        end
        pulse_frame(16'h5555);
        repeat (10) next_cyc();
        chk("coin_count", xfer_cnt, NS);
        chk("coin_pulses", drained_cnt - d0, 1);
        chk("coin_ovf", overflow, model_ovf);
        chk("coin_busy", busy, 0);
        chk("coin_valid", sample_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule

// File: doc/audio_frame_drain.md
AUDIO_FRAME_DRAIN -- requirements
Module: audio_frame_drain

Interface
REQ-001 SHALL have parameter BEATS, 64, number of 512-bit output beats per frame.
REQ-002 SHALL have parameter LANES, 32, number of 16-bit samples per beat.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 frame_done  input  1  one-cycle pulse from the audio processor: the output buffer holds a complete processed frame.
REQ-006 output_index  output  6  beat address driven to the processor read port.
REQ-007 data_out  input  512  processor read data; valid one cycle after output_index changes; lane l at bits [16l+15:16l].
REQ-008 sample_out  output  16  serialized sample, two's complement.
REQ-009 sample_valid  output  1  sample_out holds a valid sample.
REQ-010 sample_ready  input  1  downstream accepts the sample.
REQ-011 busy  output  1  high from acceptance of frame_done until the frame is fully drained.
REQ-012 frame_drained  output  1  one-cycle pulse after the final sample transfers.
REQ-013 overflow  output  1  sticky error flag.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, LOAD, STREAM.
REQ-015 IDLE: frame_done high -> FETCH, beat counter = 0, output_index = 0, busy = 1 next cycle.
REQ-016 FETCH: one wait cycle for read latency, then -> LOAD.
REQ-017 LOAD: SHALL capture data_out into a 512-bit holding register, reset lane counter to 0, then -> STREAM.
REQ-018 STREAM: sample_valid = 1 and sample_out = lane (lane counter) of the holding register.
REQ-019 Transfer occurs only on a cycle with sample_valid && sample_ready; lane counter increments by 1 per transfer.
REQ-020 sample_out and sample_valid SHALL remain stable while sample_valid && !sample_ready.
REQ-021 Transfer of lane LANES-1 with beat < BEATS-1: beat and output_index increment by 1, -> FETCH.
REQ-022 Transfer of lane LANES-1 with beat = BEATS-1: -> IDLE, frame_drained pulses for one cycle, busy = 0 and output_index = 0 in the same cycle.
REQ-023 Output order SHALL be global sample index 32*beat + lane, ascending from 0 to 2047.
REQ-024 Latency: frame_done in cycle C -> first sample_valid in cycle C+3.
REQ-025 With sample_ready held high, each beat costs 34 cycles: final transfer in cycle C+2176, frame_drained in C+2177.
REQ-026 frame_done while busy SHALL be ignored for sequencing and SHALL set overflow, which holds until rst.
REQ-027 frame_done in the same cycle as the final transfer SHALL count as overflow and SHALL NOT start a new frame.
REQ-028 sample_valid SHALL be 0 in IDLE, FETCH and LOAD.
REQ-029 output_index SHALL never exceed BEATS-1; there is no wrap beyond the frame.

Reset
REQ-030 rst SHALL force, on the next edge: state IDLE, output_index 0, sample_out 0, sample_valid 0, busy 0, frame_drained 0, overflow 0, and both counters 0.
REQ-031 rst mid-frame SHALL abandon the frame, so no further samples are emitted; rst overrides a simultaneous frame_done.

Verification
REQ-032 Ramp model with word k = k (0..2047), sample_ready=1, frame_done pulse at C -> 2048 transfers of values 0..2047 in order, first at C+3, frame_drained at C+2177.
REQ-033 Random sample_ready (50%) -> identical value sequence, no drops or duplicates, sample_out stable during every stall.
REQ-034 Second frame_done 100 cycles after the first -> overflow=1 stays high, the first frame completes normally, and there is exactly one frame_drained.
REQ-035 rst asserted after 500 transfers -> next cycle sample_valid=0, busy=0, output_index=0; a subsequent frame_done replays from value 0.
REQ-036 Back-to-back: new frame_done in the cycle after frame_drained -> the new frame starts (C'+3 valid), with overflow=0.
REQ-037 Model checks the read protocol: output_index steps 0..63 monotonically, and data_out is captured only in LOAD (one cycle after the index change).
